// File: rtl/arm_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// One word request is held with its address until the memory acknowledges it.
interface arm_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/arm_fetch_unit.sv
// ARM-style instruction fetch unit: single-outstanding memory reads into a small
// registered prefetch queue, with flush redirect and drain of in-flight data.
module arm_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    arm_fetch_unit_if.master        mem,
    input  logic                    flush,
    input  logic [31:0]             flush_addr,
    input  logic                    stall,
    output logic                    ir_valid,
    output logic [31:0]             ir,
    output logic [31:0]             ir_pc
);

    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_C      = CW'(1);
    localparam logic [31:0]     RV_ALIGNED = {RESET_VECTOR[31:2], 2'b00};

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [CW-1:0] count;
    logic [31:0]   q_ir [DEPTH];
    logic [31:0]   q_pc [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] push_idx;
    logic          unused_flush_bits;

    assign unused_flush_bits = ^flush_addr[1:0];

    // Outstanding requests count against queue space, so a push never finds it full.
    always_comb begin
        issue    = reset && !flush && (state == FETCH) && (count < DEPTH_C);
        push     = (state == WAIT) && mem.mem_ack;
        pop      = ir_valid && !stall;
        push_idx = pop ? (count - ONE_C) : count;
    end

    always_comb begin
        ir_valid = reset && (count != '0) && !flush;
        ir       = reset ? q_ir[0] : 32'h0;
        ir_pc    = reset ? q_pc[0] : 32'h0;
    end

    // The in-flight address lives in req_addr so a flush cannot disturb the bus.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_addr = RV_ALIGNED;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem.mem_req  = issue;
                    mem.mem_addr = fetch_pc;
                end
                WAIT, DRAIN: begin
                    mem.mem_req  = 1'b1;
                    mem.mem_addr = req_addr;
                end
                default: begin
                    mem.mem_req  = 1'b0;
                    mem.mem_addr = RV_ALIGNED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            fetch_pc <= RV_ALIGNED;
            req_addr <= RV_ALIGNED;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_ir[i] <= 32'h0;
                q_pc[i] <= 32'h0;
            end
        end else if (flush) begin
            // Redirect wins over everything; data still in flight must be drained.
            count    <= '0;
            fetch_pc <= {flush_addr[31:2], 2'b00};
            if ((state != FETCH) && !mem.mem_ack) begin
                state <= DRAIN;
            end else begin
                state <= FETCH;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    q_ir[i] <= q_ir[i+1];
                    q_pc[i] <= q_pc[i+1];
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == push_idx) begin
                        q_ir[i] <= mem.mem_rdata;
                        q_pc[i] <= fetch_pc;
                    end
                end
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
            case (state)
                FETCH: begin
                    if (issue) begin
                        state    <= WAIT;
                        req_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        state    <= FETCH;
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                DRAIN: begin
                    if (mem.mem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
